// File: rtl/parity_function_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared constants and helpers for the parity generator/checker.
//   PARITY_ODD     : 1 when the build uses odd parity, 0 for even parity.
//                    Selected by the PARITY_ODD_EN macro (undefined = even).
//   DEF_WIDTH      : default number of data bits per word.
//   DEF_CNT_W      : default error-counter width.
//   calc_parity()  : reference parity of a data word (zero-padded to 64 bits).
// ---------------------------------------------------------------------------
package parity_pkg;

`ifdef PARITY_ODD_EN
  localparam logic PARITY_ODD = 1'b1;
`else
  localparam logic PARITY_ODD = 1'b0;
`endif

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // Zero padding does not change an XOR reduction, so any width up to 64 fits.
  function automatic logic calc_parity(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_function_if.sv
// ---------------------------------------------------------------------------
// parity_function_if
// Bundles the generator and checker signals of parity_function.
//   master : stimulus side  (drives in_valid, d_word, chk_valid, chk_frame,
//            clr_count; receives data_frame, out_valid, chk_data, chk_err,
//            chk_done, err_count)
//   slave  : parity_function side (the reverse directions)
// ---------------------------------------------------------------------------
interface parity_function_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();
  // Generator path
  logic             in_valid;
  logic [WIDTH-1:0] d_word;
  logic [WIDTH:0]   data_frame;
  logic             out_valid;
  // Checker path
  logic             chk_valid;
  logic [WIDTH:0]   chk_frame;
  logic [WIDTH-1:0] chk_data;
  logic             chk_err;
  logic             chk_done;
  logic [CNT_W-1:0] err_count;
  logic             clr_count;

  modport master (
    output in_valid, d_word, chk_valid, chk_frame, clr_count,
    input  data_frame, out_valid, chk_data, chk_err, chk_done, err_count
  );

  modport slave (
    input  in_valid, d_word, chk_valid, chk_frame, clr_count,
    output data_frame, out_valid, chk_data, chk_err, chk_done, err_count
  );
endinterface

// File: rtl/parity_function_tree.sv
// ---------------------------------------------------------------------------
// parity_tree
// Balanced XOR-reduction tree with an output inversion.
//   data_i   : W input bits
//   invert_i : 1 inverts the reduction (odd parity / odd-parity check)
//   parity_o : XOR of all data_i bits, XOR invert_i
// The input is zero-padded to the next power of two so every level halves
// cleanly; depth is ceil(log2(W)).
// ---------------------------------------------------------------------------
module parity_tree #(
  parameter int W = 8
) (
  input  logic [W-1:0] data_i,
  input  logic         invert_i,
  output logic         parity_o
);
  localparam int LEVELS = (W > 1) ? $clog2(W) : 0;
  localparam int P      = 1 << LEVELS;

  logic [P-1:0]            leaf;
  logic [LEVELS:0][P-1:0]  lvl;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < W) begin : g_data
        assign leaf[gi] = data_i[gi];
      end else begin : g_pad
        assign leaf[gi] = 1'b0;
      end
    end
  endgenerate

  // Level l holds P>>l partial results; the unused upper bits stay zero.
  always_comb begin
    lvl    = '0;
    lvl[0] = leaf;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int k = 0; k < (P >> l); k++) begin
        lvl[l][k] = lvl[l-1][2*k] ^ lvl[l-1][2*k+1];
      end
    end
  end

  assign parity_o = lvl[LEVELS][0] ^ invert_i;
endmodule

// File: rtl/parity_function.sv
// ---------------------------------------------------------------------------
// parity_function
// Parameterised parity generator/checker with a saturating error counter.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : parity_function_if.slave
//           generator: in_valid/d_word -> data_frame {d_word, parity}, out_valid
//           checker  : chk_valid/chk_frame -> chk_data, chk_err, chk_done
//           counter  : err_count (saturating), clr_count (synchronous clear)
// Both paths have one cycle of latency and run independently.
// Build option: define PARITY_ODD_EN for odd parity (default even parity).
// ---------------------------------------------------------------------------
module parity_function
  import parity_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  parity_function_if.slave bus
);
  logic             gen_par;
  logic             chk_bad;

  logic [WIDTH:0]   frame_q,     frame_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] chk_data_q,  chk_data_d;
  logic             chk_err_q,   chk_err_d;
  logic             chk_done_q,  chk_done_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  // Generator: parity over the data word only.
  parity_tree #(.W(WIDTH)) u_gen_tree (
    .data_i   (bus.d_word),
    .invert_i (PARITY_ODD),
    .parity_o (gen_par)
  );

  // Checker: reduction over the whole frame; with the same inversion a
  // correctly formed frame yields 0, so the result is directly the error flag.
  parity_tree #(.W(WIDTH + 1)) u_chk_tree (
    .data_i   (bus.chk_frame),
    .invert_i (PARITY_ODD),
    .parity_o (chk_bad)
  );

  always_comb begin
    frame_d     = frame_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      frame_d = {bus.d_word, gen_par};
    end

    chk_data_d = chk_data_q;
    chk_err_d  = 1'b0;
    chk_done_d = bus.chk_valid;
    if (bus.chk_valid) begin
      chk_data_d = bus.chk_frame[WIDTH:1];
      chk_err_d  = chk_bad;
    end

    // Clear wins over a same-cycle increment; the counter sticks at all-ones.
    cnt_d = cnt_q;
    if (bus.clr_count) begin
      cnt_d = '0;
    end else if (bus.chk_valid && chk_bad && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      chk_data_q  <= '0;
      chk_err_q   <= 1'b0;
      chk_done_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
      chk_data_q  <= chk_data_d;
      chk_err_q   <= chk_err_d;
      chk_done_q  <= chk_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.data_frame = frame_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.chk_data   = chk_data_q;
  assign bus.chk_err    = chk_err_q;
  assign bus.chk_done   = chk_done_q;
  assign bus.err_count  = cnt_q;
endmodule

// File: tb/tb_parity_function.sv
// ---------------------------------------------------------------------------
// tb_parity_function
// Scoreboard bench for parity_function (WIDTH=8, CNT_W=4). Each driven cycle
// pushes the expected register contents; one clock later they are popped and
// compared against the outputs. Honours PARITY_ODD_EN like the design.
// ---------------------------------------------------------------------------
module tb_parity_function;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef struct {
    logic             ov;
    logic [WIDTH:0]   df;
    logic             cd;
    logic             ce;
    logic [WIDTH-1:0] cdat;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  parity_function_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  parity_function #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  exp_t sb[$];

  // Reference model state
  logic [WIDTH:0]   m_frame = '0;
  logic [WIDTH-1:0] m_data  = '0;
  logic [CNT_W-1:0] m_cnt   = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model_frame(input logic [WIDTH-1:0] w);
    return {w, (^w) ^ ODD};
  endfunction

  function automatic logic model_err(input logic [WIDTH:0] f);
    return (^f) ^ ODD;
  endfunction

  // Drive one cycle (called at posedge+1), push expectation, then compare
  // the registered outputs one edge later.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] w,
                       input logic cv, input logic [WIDTH:0] f, input logic clr);
    exp_t e;
    exp_t got;
    bus.in_valid  = iv;
    bus.d_word    = w;
    bus.chk_valid = cv;
    bus.chk_frame = f;
    bus.clr_count = clr;
    if (iv) m_frame = model_frame(w);
    if (cv) m_data = f[WIDTH:1];
    if (clr) m_cnt = '0;
    else if (cv && model_err(f) && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    e.ov = iv; e.df = m_frame; e.cd = cv; e.ce = cv & model_err(f);
    e.cdat = m_data; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      check("out_valid",  64'(bus.out_valid),  64'(got.ov));
      check("data_frame", 64'(bus.data_frame), 64'(got.df));
      check("chk_done",   64'(bus.chk_done),   64'(got.cd));
      check("chk_err",    64'(bus.chk_err),    64'(got.ce));
      check("chk_data",   64'(bus.chk_data),   64'(got.cdat));
      check("err_count",  64'(bus.err_count),  64'(got.cnt));
      $display("txn %0d: ov=%0d df=%03h cd=%0d ce=%0d cdat=%02h cnt=%0d",
               n_txn, bus.out_valid, bus.data_frame, bus.chk_done,
               bus.chk_err, bus.chk_data, bus.err_count);
    end
    n_txn++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_df"},  64'(bus.data_frame), 64'd0);
    check({tag, "_ov"},  64'(bus.out_valid),  64'd0);
    check({tag, "_cd"},  64'(bus.chk_data),   64'd0);
    check({tag, "_ce"},  64'(bus.chk_err),    64'd0);
    check({tag, "_cdn"}, 64'(bus.chk_done),   64'd0);
    check({tag, "_cnt"}, 64'(bus.err_count),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH:0] good;
    logic [WIDTH:0] fb;
    bus.in_valid = 1'b0; bus.d_word = '0; bus.chk_valid = 1'b0;
    bus.chk_frame = '0; bus.clr_count = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Exhaustive sweep with loopback of the previous frame into the checker
    for (int i = 0; i <= 256; i++) begin
      fb = bus.data_frame;
      cycle(i < 256, WIDTH'(i), i > 0, fb, 1'b0);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b0);

    // Error injection: parity bit flipped, then a data bit flipped
    good = model_frame(8'h01);
    cycle(1'b0, '0, 1'b1, good ^ 9'h001, 1'b0);
    cycle(1'b0, '0, 1'b1, good ^ 9'h004, 1'b0);
    cycle(1'b0, '0, 1'b1, good, 1'b0);

    // Saturation: 20 bad frames with varied data
    for (int i = 0; i < 20; i++) begin
      good = model_frame(WIDTH'($urandom_range(0, 255)));
      cycle(1'b1, WIDTH'(i * 37), 1'b1, good ^ (9'h001 << (i % 9)), 1'b0);
    end
    // Clear beats a simultaneous bad frame, then counting resumes
    cycle(1'b0, '0, 1'b1, model_frame(8'h5A) ^ 9'h010, 1'b1);
    cycle(1'b0, '0, 1'b1, model_frame(8'h5A) ^ 9'h010, 1'b0);

    // Odd/even boundary words
    cycle(1'b1, 8'h00, 1'b1, 9'h000, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 9'h1FF, 1'b0);

    // Reset mid-stream while both paths are busy
    bus.in_valid = 1'b1; bus.d_word = 8'h3C;
    bus.chk_valid = 1'b1; bus.chk_frame = 9'h003; bus.clr_count = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    m_frame = '0; m_data = '0; m_cnt = '0;
    @(posedge clk);
    #1;
    check_all_zero("rsthold");
    rst_n = 1'b1;
    cycle(1'b1, 8'hA5, 1'b1, model_frame(8'hC3) ^ 9'h100, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_function.md
Name: parity_function

Overview:
- Parameterised parity generator/checker.
- Generator path: appends a parity bit to a width-bit data word and registers the resulting (width+1)-bit frame.
- Checker path: verifies received frames, flags errors and keeps a saturating error count.
- Sits at link/serialiser boundaries wherever a word needs a single-bit integrity check.

Parameters:
- WIDTH, 8, number of data bits per word; legal range 1..64.
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock; all registers on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  d_word is valid this cycle.
- d_word  input  WIDTH  data word to protect.
- data_frame  output  WIDTH+1  registered frame {d_word, parity}; parity in bit 0.
- out_valid  output  1  data_frame is valid.
- chk_valid  input  1  chk_frame is valid this cycle.
- chk_frame  input  WIDTH+1  received frame {data, parity}; parity in bit 0.
- chk_data  output  WIDTH  registered data field of chk_frame (bits WIDTH:1).
- chk_err  output  1  registered parity-mismatch flag.
- chk_done  output  1  chk_err/chk_data are valid.
- err_count  output  CNT_W  saturating count of detected errors.
- clr_count  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n low, asynchronous) forces these outputs to 0 until rst_n is released: data_frame, out_valid, chk_data, chk_err, chk_done, err_count.
- Parity function: p = XOR reduction of all data bits (even parity: total count of 1s in the frame is even).
- Generator, one-cycle latency:
  - On a clock edge with in_valid=1: data_frame <= {d_word, p(d_word)} and out_valid <= 1.
  - With in_valid=0: out_valid <= 0 and data_frame holds its last value.
- Checker, one-cycle latency:
  - On a clock edge with chk_valid=1: chk_data <= chk_frame[WIDTH:1], chk_err <= XOR of all WIDTH+1 bits of chk_frame, chk_done <= 1.
  - With chk_valid=0: chk_done <= 0, chk_err <= 0, chk_data holds.
- err_count increments by 1 on each clock edge where chk_valid=1 and the frame has odd weight.
- err_count saturates at all-ones; it never wraps.
- clr_count=1 sets err_count to 0 on the next edge. Clear takes priority over a simultaneous increment.
- Generator and checker are independent and may both be active in the same cycle.
- Reset asserted mid-stream discards any pending result; the first valid output after reset release corresponds to the first input accepted after release.
- No back-pressure; every valid input is accepted.
- Boundary cases: d_word all-zeros -> parity 0; all-ones -> parity = WIDTH mod 2.

Optional Feature:
- Macro PARITY_ODD_EN.
- When defined: odd parity.
  - Generator bit = ~XOR(d_word).
  - chk_err = ~XOR(chk_frame), i.e. a frame of even weight is an error.
- When undefined: even parity as specified above.
- Reset values, latency and counter behaviour are identical in both builds.

Decomposition:
- Package parity_pkg:
  - PARITY_ODD constant, derived from PARITY_ODD_EN.
  - Function calc_parity(data, odd) returning 1 bit.
  - Default WIDTH/CNT_W localparams.
- Sub-module parity_tree:
  - Parameterised balanced XOR-reduction tree with an invert input.
  - Instantiated twice: once over WIDTH bits for the generator, once over WIDTH+1 bits for the checker.
- The top module holds registers, valid flags and the counter.

Test Plan:
- Exhaustive sweep, WIDTH=8, in_valid=1: d_word 0..255 one per cycle -> each data_frame one cycle later = {d_word, XOR(d_word)}, e.g. 8'h00->9'h000, 8'h01->9'h003, 8'hFF->9'h1FE, 8'h07->9'h00F; out_valid high throughout.
- Loopback: feed every data_frame back into chk_frame -> chk_err=0 for all 256 words, chk_data equals the original word, err_count stays 0.
- Error injection: chk_frame=9'h003 with bit 0 flipped to 9'h002 -> chk_err=1 next cycle, err_count=1. Flipping a data bit (9'h007) also gives chk_err=1 and err_count=2.
- Counter saturation and clear, CNT_W=4: 20 bad frames -> err_count sticks at 4'hF. Assert clr_count together with a bad frame -> err_count=0.
- Reset mid-stream: assert rst_n=0 between clock edges while in_valid/chk_valid are high -> all outputs 0 immediately. After release, the first valid word appears after exactly one cycle.
- PARITY_ODD_EN build: d_word 8'h00 -> data_frame 9'h001; chk_frame 9'h000 -> chk_err=1.
